// File: rtl/quad_reg_write.sv
`default_nettype none
// ============================================================================
// Module   : quad_reg_write
// Purpose  : Write side of a 4-entry register bank. A valid/ready write port
//            feeds a one-entry write-back stage. The stage commits to the
//            decoded register on the next unstalled edge. All four committed
//            register values drive the read-mux inputs continuously.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            wr_valid/wr_ready     - write request handshake
//            wr_dst, wr_data       - destination index and write data
//            hold                  - stalls the commit of the pending entry
//            pend_valid, pend_dst  - pending-write status for hazard checks
//            regread0..regread3    - committed register contents
// Revision : 1.0 - initial release
// ============================================================================
module quad_reg_write #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               ZERO_REG0 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_dst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hold,
  output logic             pend_valid,
  output logic [1:0]       pend_dst,
  output logic [WIDTH-1:0] regread0,
  output logic [WIDTH-1:0] regread1,
  output logic [WIDTH-1:0] regread2,
  output logic [WIDTH-1:0] regread3
);

  logic             r_pend_valid;
  logic [1:0]       r_pend_dst;
  logic [WIDTH-1:0] r_pend_data;
  logic [WIDTH-1:0] r_regs [4];

  logic             w_accept;
  logic             w_commit;
  logic [3:0]       w_wr_en;

  // The stage frees up on the same edge it commits, so a new request can
  // be taken whenever the stage is empty or is not stalled.
  assign wr_ready = ~r_pend_valid | ~hold;
  assign w_accept = wr_valid & wr_ready;
  assign w_commit = r_pend_valid & ~hold;

  // One-hot decode of the pending destination. When register 0 is
  // hard-wired its enable is tied off, so a write to it just retires.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      if ((gi == 0) && (ZERO_REG0 != 0)) begin : g_zero
        assign w_wr_en[gi] = 1'b0;
      end else begin : g_rw
        assign w_wr_en[gi] = w_commit & (r_pend_dst == 2'(gi));
      end
    end
  endgenerate

  // Write-back stage. A concurrent accept overrides the retire, since
  // the old entry is consumed by the bank on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_dst   <= 2'd0;
      r_pend_data  <= '0;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_dst   <= wr_dst;
      r_pend_data  <= wr_data;
    end else if (w_commit) begin
      r_pend_valid <= 1'b0;
      r_pend_dst   <= 2'd0;
    end
  end

  // Register bank: only committed values are ever visible (no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= r_pend_data;
        end
      end
    end
  end

  assign pend_valid = r_pend_valid;
  assign pend_dst   = r_pend_dst;
  assign regread0   = r_regs[0];
  assign regread1   = r_regs[1];
  assign regread2   = r_regs[2];
  assign regread3   = r_regs[3];

endmodule
`default_nettype wire

// File: tb/tb_quad_reg_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_reg_write
// Purpose  : Self-checking bench for quad_reg_write. Two instances share the
//            same stimulus: one with register 0 hard-wired, one with it
//            writable. Accepted writes are queued and retired against the
//            bank when the commit condition holds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_reg_write;

  typedef struct {
    logic [1:0] dst;
    logic [3:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [1:0] wr_dst;
  logic [3:0] wr_data;
  logic       hold;

  logic       wr_ready_z, pend_valid_z;
  logic [1:0] pend_dst_z;
  logic [3:0] rz0, rz1, rz2, rz3;
  logic       wr_ready_n, pend_valid_n;
  logic [1:0] pend_dst_n;
  logic [3:0] rn0, rn1, rn2, rn3;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t sb[$];
  logic [3:0] mz[4];
  logic [3:0] mn[4];

  quad_reg_write #(.WIDTH(4), .RESET_VAL(4'h0), .ZERO_REG0(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_z),
    .wr_dst(wr_dst), .wr_data(wr_data), .hold(hold),
    .pend_valid(pend_valid_z), .pend_dst(pend_dst_z),
    .regread0(rz0), .regread1(rz1), .regread2(rz2), .regread3(rz3)
  );

  quad_reg_write #(.WIDTH(4), .RESET_VAL(4'h0), .ZERO_REG0(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_n),
    .wr_dst(wr_dst), .wr_data(wr_data), .hold(hold),
    .pend_valid(pend_valid_n), .pend_dst(pend_dst_n),
    .regread0(rn0), .regread1(rn1), .regread2(rn2), .regread3(rn3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      mz[i] = 4'h0;
      mn[i] = 4'h0;
    end
  endtask

  // Compare every visible output of both instances against the model.
  task automatic check_state(input string tag);
    logic       exp_pv;
    logic [1:0] exp_pd;
    exp_pv = (sb.size() != 0);
    exp_pd = exp_pv ? sb[0].dst : 2'd0;
    check_val({tag, " pend_valid_z"}, pend_valid_z, exp_pv);
    check_val({tag, " pend_valid_n"}, pend_valid_n, exp_pv);
    check_val({tag, " pend_dst_z"}, pend_dst_z, exp_pd);
    check_val({tag, " pend_dst_n"}, pend_dst_n, exp_pd);
    check_val({tag, " regread0_z"}, rz0, mz[0]);
    check_val({tag, " regread1_z"}, rz1, mz[1]);
    check_val({tag, " regread2_z"}, rz2, mz[2]);
    check_val({tag, " regread3_z"}, rz3, mz[3]);
    check_val({tag, " regread0_n"}, rn0, mn[0]);
    check_val({tag, " regread1_n"}, rn1, mn[1]);
    check_val({tag, " regread2_n"}, rn2, mn[2]);
    check_val({tag, " regread3_n"}, rn3, mn[3]);
  endtask

  // One clock cycle: drive inputs, check ready, update the scoreboard for
  // the edge, then check the post-edge state.
  task automatic step(input string tag, input logic v, input logic [1:0] d,
                      input logic [3:0] dat, input logic h, output logic acc);
    logic exp_ready;
    logic com;
    wr_t  e;
    @(negedge clk);
    wr_valid = v;
    wr_dst   = d;
    wr_data  = dat;
    hold     = h;
    #1;
    exp_ready = (sb.size() == 0) || !h;
    check_val({tag, " wr_ready_z"}, wr_ready_z, exp_ready);
    check_val({tag, " wr_ready_n"}, wr_ready_n, exp_ready);
    acc = v && exp_ready;
    com = (sb.size() != 0) && !h;
    if (com) begin
      e = sb.pop_front();
      check_val({tag, " commit_dst"}, pend_dst_z, e.dst);
      if (e.dst != 2'd0) mz[e.dst] = e.data;
      mn[e.dst] = e.data;
    end
    if (acc) begin
      e.dst  = d;
      e.data = dat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  logic       acc;
  logic       rv;
  logic [1:0] rd;
  logic [3:0] rdat;

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_dst   = 2'd0;
    wr_data  = 4'h0;
    hold     = 1'b0;
    clear_model();

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    check_val("reset wr_ready", wr_ready_z, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b0, 2'd0, 4'h0, 1'b0, acc);

    // Single write
    step("single_acc", 1'b1, 2'd2, 4'hA, 1'b0, acc);
    check_val("single pend_dst", pend_dst_z, 2'd2);
    step("single_com", 1'b0, 2'd0, 4'h0, 1'b0, acc);
    check_val("single regread2", rz2, 4'hA);

    // Back-to-back writes
    step("b2b_1", 1'b1, 2'd1, 4'h3, 1'b0, acc);
    step("b2b_2", 1'b1, 2'd3, 4'hC, 1'b0, acc);
    step("b2b_3", 1'b1, 2'd1, 4'hF, 1'b0, acc);
    step("b2b_d", 1'b0, 2'd0, 4'h0, 1'b0, acc);
    check_val("b2b regread1", rz1, 4'hF);
    check_val("b2b regread3", rz3, 4'hC);

    // Hold stall
    step("hold_acc", 1'b1, 2'd1, 4'h5, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step("hold_stall", 1'b1, 2'd2, 4'h6, 1'b1, acc);
      check_val("hold regread1", rz1, 4'hF);
    end
    step("hold_rel", 1'b1, 2'd2, 4'h6, 1'b0, acc);
    check_val("hold_rel regread1", rz1, 4'h5);
    check_val("hold_rel accepted", acc, 1'b1);
    step("hold_com", 1'b0, 2'd0, 4'h0, 1'b0, acc);
    check_val("hold_com regread2", rz2, 4'h6);

    // Zero register
    step("zero_acc", 1'b1, 2'd0, 4'h7, 1'b0, acc);
    step("zero_com", 1'b0, 2'd0, 4'h0, 1'b0, acc);
    check_val("zero regread0_z", rz0, 4'h0);
    check_val("zero regread0_n", rn0, 4'h7);
    check_val("zero pend_valid", pend_valid_z, 1'b0);

    // Reset mid-operation
    step("mid_r3", 1'b1, 2'd3, 4'h9, 1'b0, acc);
    step("mid_acc", 1'b1, 2'd1, 4'hE, 1'b0, acc);
    check_val("mid regread3", rz3, 4'h9);
    #2;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    #1;
    clear_model();
    check_state("mid_reset");
    check_val("mid_reset wr_ready", wr_ready_z, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("post_reset", 1'b0, 2'd0, 4'h0, 1'b0, acc);
      check_val("post_reset regread1", rz1, 4'h0);
    end

    // Random traffic with stalls; a refused request is held stable.
    acc  = 1'b1;
    rv   = 1'b0;
    rd   = 2'd0;
    rdat = 4'h0;
    for (int i = 0; i < 80; i++) begin
      if (acc || !rv) begin
        rv   = ($urandom_range(0, 3) != 0);
        rd   = 2'($urandom_range(0, 3));
        rdat = 4'($urandom_range(0, 15));
      end
      step("rand", rv, rd, rdat, ($urandom_range(0, 3) == 0), acc);
    end
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, 2'd0, 4'h0, 1'b0, acc);
    end
    check_val("drain empty", pend_valid_z, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
